data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
Two-requester arbiter and sequencer for the 4096 x 16 data memory. The memory has a combinational read and a posedge write. Port 0 serves the CPU datapath and port 1 serves a loader/DMA requester. The block picks one requester per transaction, drives the memory's store/load/address/data signals for exactly one cycle, captures read data and returns a one-cycle acknowledge.

Parameters:
ADDR_W, 12, memory address width (4096 words)
DATA_W, 16, memory word width
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous reset, active low
req0  input  1  port 0 transaction request
we0  input  1  port 0 write enable (1 = store, 0 = load)
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 store data
ack0  output  1  port 0 transaction complete, one-cycle pulse
rdata0  output  DATA_W  port 0 load result, registered
req1, we1, addr1, wdata1, ack1, rdata1  same widths and meaning as port 0, for port 1
mem_store  output  1  to memory store-enable
mem_load  output  1  to memory load-enable
mem_addr  output  ADDR_W  to memory address
mem_wdata  output  DATA_W  to memory input value
mem_rdata  input  DATA_W  from memory output value (combinational)
busy  output  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, ACCESS, DONE. One transaction takes 3 cycles; peak throughput is 1 transaction per 3 cycles.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select the winner and latch its we/addr/wdata into internal registers, set owner, then go to ACCESS.
  - Single requester: that port wins.
  - Both requesting with FIXED_PRIO=0: the port != last_owner wins.
  - Both requesting with FIXED_PRIO=1: port 0 wins.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr, mem_wdata = latched wdata, mem_store = latched we, mem_load = ~latched we.
  - The memory write commits on the rising edge that ends ACCESS.
  - For a load, mem_rdata is captured into the owner's rdata register on that same edge.
  - Next state is DONE.
- DONE:
  - The owner's ack is 1 for this single cycle; the other ack stays 0.
  - last_owner <= owner; next state is IDLE.
- Outside ACCESS: mem_store = 0, mem_load = 0, mem_addr = 0, mem_wdata = 0. The memory therefore sees load = 0 and outputs 0 at all other times.
- rdata0/rdata1:
  - Updated only by a load owned by that port.
  - Stores and the other port's traffic leave them unchanged.
  - Valid from the DONE cycle onward.
- Requester protocol:
  - Hold req, we, addr and wdata stable from req rise until ack is seen high.
  - The request is sampled again in the IDLE cycle after DONE. Keeping req high on the ack edge therefore issues a back-to-back transaction.
  - Dropping req on the ack edge ends the sequence.
- Requests arriving while busy wait; none are dropped. With round-robin, a port continuously requesting is served within 2 transactions (no starvation).
- With FIXED_PRIO=1, port 1 may starve under continuous port 0 traffic. This is accepted.
- Reset (sampled at a rising edge with rst_n = 0):
  - state = IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, last_owner = 1 (port 0 wins the first tie), latched request registers = 0, busy = 0.
  - Reset during ACCESS: the store driven in that cycle may commit at the reset edge, because the memory contents are not reset. No ack is issued, and the requester must reissue.
  - Reset during DONE: the ack pulse of that cycle has already been seen; nothing further happens.
- The memory contents are never cleared by this block.

Test Plan:
1. Reset, then req0 = 1, we0 = 1, addr0 = 12'h010, wdata0 = 16'hBEEF for one transaction -> mem_store = 1 only in cycle 2 with mem_addr = 12'h010; ack0 high in cycle 3; ack1 stays 0; busy high for cycles 2-3.
2. After test 1, req1 = 1, we1 = 0, addr1 = 12'h010 -> mem_load = 1 in ACCESS; rdata1 = 16'hBEEF with ack1 = 1 in DONE; rdata0 unchanged at 16'h0000.
3. From reset, req0 and req1 rise in the same cycle (both loads, addresses 12'h001 and 12'h002), FIXED_PRIO = 0 -> port 0 served first (ack0 at cycle 3), port 1 next (ack1 at cycle 6), with no idle gap beyond the IDLE cycle.
4. Both reqs held high for 6 transactions, FIXED_PRIO = 0 -> grants alternate 0,1,0,1,0,1; each port sees exactly 3 acks.
5. Same as test 4 with FIXED_PRIO = 1 -> six consecutive acks to port 0; ack1 never asserted until req0 drops, then port 1 is served within 3 cycles.
6. Port 0 store (addr 12'h020, data 16'h1234); rst_n = 0 during ACCESS -> next cycle state IDLE, busy = 0, ack0 never pulses, rdata0 = rdata1 = 0; after reset, a port 1 load of 12'h020 completes normally and returns a defined value (1234 or the prior content).

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for a 4096x16 data memory: IDLE -> ACCESS -> DONE, 3 cycles per transaction.
// Requesters hold req/we/addr/wdata until their one-cycle ack; losing requests simply wait in IDLE.
module data_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_store,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_grant1;

    // On a tie, round-robin hands the grant to whichever port did not own the last transaction.
    always_comb begin
        w_grant1 = 1'b0;
        if (req1 && !req0) begin
            w_grant1 = 1'b1;
        end else if (req1 && req0) begin
            w_grant1 = (FIXED_PRIO == 0) ? !r_last_owner : 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_store   = 1'b0;
        mem_load    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_store   = r_we;
                mem_load    = !r_we;
                mem_addr    = r_addr;
                mem_wdata   = r_wdata;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ack0        = !r_owner;
                ack1        = r_owner;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && (req0 || req1)) begin
                r_owner <= w_grant1;
                r_we    <= w_grant1 ? we1    : we0;
                r_addr  <= w_grant1 ? addr1  : addr0;
                r_wdata <= w_grant1 ? wdata1 : wdata0;
            end
            // Memory read is combinational, so load data is captured on the edge that ends ACCESS.
            if (r_state == ST_ACCESS && !r_we) begin
                if (r_owner) r_rdata1 <= mem_rdata;
                else         r_rdata0 <= mem_rdata;
            end
            if (r_state == ST_DONE) r_last_owner <= r_owner;
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
endmodule
